timegen_multi: RTL and testbench
================================

# timegen_multi

Parametrised time base for the alarm-clock datapath, the successor of the fixed 256 Hz second/minute pulse generator. From one free-running clock it produces aligned single-cycle one_second, one_minute and one_hour strobes and exposes the running seconds and minutes counts. Clock rate and rollover limits are parameters. The block adds a count-enable (pause), an hour strobe, and a fully registered fastwatch mode. It sits between the clock source and the alarm controller and counter blocks.

## Interface
- CLK_HZ, 256, clock cycles per second; must be ≥ 2
- SEC_PER_MIN, 60, seconds per minute rollover; must be ≥ 2
- MIN_PER_HOUR, 60, minutes per hour rollover; must be ≥ 2
- Derived widths: PW = $clog2(CLK_HZ), SW = $clog2(SEC_PER_MIN), MW = $clog2(MIN_PER_HOUR)
- clock  input  1  the single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on the clock rising edge
- reset_count  input  1  synchronous clear of all time-base state, asserted when a new current time is loaded
- enable  input  1  count enable; low = pause
- fastwatch  input  1  fast mode: each second event is treated as a minute event
- one_second  output  1  single-cycle strobe, once per second event
- one_minute  output  1  single-cycle strobe, once per minute event
- one_hour  output  1  single-cycle strobe, once per hour event
- sec_count  output  SW  seconds within the current minute, 0..SEC_PER_MIN-1
- min_count  output  MW  minutes within the current hour, 0..MIN_PER_HOUR-1

## Operation
- State: prescaler presc (PW bits, range 0..CLK_HZ-1), sec_count, min_count, and three registered strobes. All outputs come directly from flops; there is no combinational path from input to output.
- Priority per rising edge, highest first: reset=0, then reset_count=1, then enable=0, then normal counting.
- reset=0: presc, sec_count, min_count and all strobes are cleared to 0.
- reset_count=1: the same clear as reset. It takes effect even while enable=0.
- enable=0: presc, sec_count and min_count hold their values. All strobes are driven to 0.
- Normal counting:
  - If presc < CLK_HZ-1: presc increments.
  - Otherwise: presc wraps to 0 and a second event (SE) occurs.
- On SE with fastwatch=0:
  - one_second=1.
  - If sec_count == SEC_PER_MIN-1: sec_count wraps to 0 and a minute event (ME) occurs. Otherwise sec_count increments.
- On SE with fastwatch=1:
  - one_second=1 and an ME occurs.
  - sec_count is forced to 0.
- On ME:
  - one_minute=1.
  - If min_count == MIN_PER_HOUR-1: min_count wraps to 0 and one_hour=1. Otherwise min_count increments.
- A strobe that is not set on a given edge is 0 after that edge.
- Coincident events: one_second, one_minute and one_hour assert on the same cycle when their conditions coincide. There is never a one-cycle skew between them.
- Mode change:
  - fastwatch is sampled only on SE edges.
  - Toggling it between SEs has no effect until the next SE.
  - Entering fastwatch discards any partial seconds (sec_count becomes 0 at that SE). min_count is kept.
- Arithmetic is unsigned. Every wrap compares against the parameter value minus 1, so non-power-of-two limits never reach unused codes.

## Timing
- Reset value of every output is 0: one_second, one_minute, one_hour, sec_count, min_count.
- Latency: one_second first asserts on the CLK_HZ-th enabled edge after reset or reset_count is released.
  - Example: edge 256 for the default parameters.
  - Thereafter the period is exactly CLK_HZ enabled edges.
- Strobe width is exactly one clock cycle, including when enable drops on the cycle after a strobe.
- one_minute period is CLK_HZ*SEC_PER_MIN enabled edges (fastwatch=0) or CLK_HZ (fastwatch=1).
- one_hour period is one_minute period × MIN_PER_HOUR.
- sec_count and min_count update on the same edge as the strobes that accompany them.
- Pause: enable low for N cycles stretches every subsequent event by exactly N cycles. No event is lost or duplicated.
- reset_count on the same edge as an SE wins: no strobe is produced and all counts are 0.

## Test plan
- Default parameters; release reset, enable=1 → one_second high for one cycle on edge 256 and every 256 thereafter; sec_count steps 0→1→…→59→0; one_minute coincides with the 60th one_second (edge 15360).
- CLK_HZ=4, SEC_PER_MIN=3, MIN_PER_HOUR=2 → one_second every 4 edges, one_minute every 12, one_hour every 24; all three high together on edge 24; counts back at 0.
- Same small parameters, fastwatch=1 from reset → one_minute == one_second every 4 edges; sec_count stays 0; one_hour on edge 8.
- Default parameters, enable=0 for 100 cycles starting at edge 100 → first one_second moves to edge 356; counts frozen during the pause; strobes 0 throughout the pause.
- reset_count pulsed on the exact edge where presc == CLK_HZ-1 and sec_count == 59 → no strobes; next one_second arrives CLK_HZ edges later with sec_count=1, min_count=0.
- reset held low for 3 cycles mid-minute → all outputs 0 on the first low edge; count restarts from 0 once reset is high.

Source files
------------

// File: rtl/timegen_multi.sv
// timegen_multi: parametrised time base for the alarm-clock datapath.
// Divides the free-running clock into aligned single-cycle one_second,
// one_minute and one_hour strobes and exposes the running seconds and
// minutes counts. Supports a pause (enable low) and a fastwatch mode in
// which every second event also counts as a minute event.
module timegen_multi #(
   parameter int CLK_HZ       = 256,
   parameter int SEC_PER_MIN  = 60,
   parameter int MIN_PER_HOUR = 60,
   localparam int PW = $clog2(CLK_HZ),
   localparam int SW = $clog2(SEC_PER_MIN),
   localparam int MW = $clog2(MIN_PER_HOUR)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          reset_count,
   input  logic          enable,
   input  logic          fastwatch,
   output logic          one_second,
   output logic          one_minute,
   output logic          one_hour,
   output logic [SW-1:0] sec_count,
   output logic [MW-1:0] min_count
);

   // Terminal values: every wrap compares against limit-1 so that
   // non-power-of-two limits never step into unused codes.
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_PER_MIN - 1);
   localparam logic [MW-1:0] MIN_LAST   = MW'(MIN_PER_HOUR - 1);

   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic [SW-1:0] sec_next;
   logic [MW-1:0] min_next;
   logic          sec_event;
   logic          min_event;
   logic          hour_event;

   // Next-state decode for one enabled counting edge; the register block
   // below decides whether it is applied (reset, clear, pause).
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      presc_next = presc + 1'b1;
      sec_next   = sec_count;
      min_next   = min_count;
      sec_event  = 1'b0;
      min_event  = 1'b0;
      hour_event = 1'b0;

      if (presc == PRESC_LAST) begin
         presc_next = '0;
         sec_event  = 1'b1;
         // fastwatch is only looked at here, so toggling it between
         // second events has no effect; entering it drops partial seconds.
         if (fastwatch) begin
            sec_next  = '0;
            min_event = 1'b1;
         end else if (sec_count == SEC_LAST) begin
            sec_next  = '0;
            min_event = 1'b1;
         end else begin
            sec_next  = sec_count + 1'b1;
         end
      end

      if (min_event) begin
         if (min_count == MIN_LAST) begin
            min_next   = '0;
            hour_event = 1'b1;
         end else begin
            min_next   = min_count + 1'b1;
         end
      end
   end

   // State and registered strobes; priority reset > reset_count > pause.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values and simulation matches the hardware.
      if (!reset) begin
         presc      <= '0;
         sec_count  <= '0;
         min_count  <= '0;
         one_second <= 1'b0;
         one_minute <= 1'b0;
         one_hour   <= 1'b0;
      end else if (reset_count) begin
         // Loading a new time restarts the base, even while paused.
         presc      <= '0;
         sec_count  <= '0;
         min_count  <= '0;
         one_second <= 1'b0;
         one_minute <= 1'b0;
         one_hour   <= 1'b0;
      end else if (!enable) begin
         // Paused: counts hold, strobes still end after one cycle.
         one_second <= 1'b0;
         one_minute <= 1'b0;
         one_hour   <= 1'b0;
      end else begin
         presc      <= presc_next;
         sec_count  <= sec_next;
         min_count  <= min_next;
         one_second <= sec_event;
         one_minute <= min_event;
         one_hour   <= hour_event;
      end
   end

endmodule

// File: tb/tb_timegen_multi.sv
// tb_timegen_multi: directed bench for timegen_multi. One instance uses the
// default parameters, a second uses CLK_HZ=4, SEC_PER_MIN=3, MIN_PER_HOUR=2.
// Expected values are computed from edge numbers counted by the bench.
module tb_timegen_multi;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Default-parameter instance
   logic       d_reset, d_rc, d_en, d_fw;
   logic       d_os, d_om, d_oh;
   logic [5:0] d_sec;
   logic [5:0] d_min;

   // Small-parameter instance
   logic       s_reset, s_rc, s_en, s_fw;
   logic       s_os, s_om, s_oh;
   logic [1:0] s_sec;
   logic [0:0] s_min;

   timegen_multi u_dut_def (
      .clock       (clock),
      .reset       (d_reset),
      .reset_count (d_rc),
      .enable      (d_en),
      .fastwatch   (d_fw),
      .one_second  (d_os),
      .one_minute  (d_om),
      .one_hour    (d_oh),
      .sec_count   (d_sec),
      .min_count   (d_min)
   );

   timegen_multi #(
      .CLK_HZ       (4),
      .SEC_PER_MIN  (3),
      .MIN_PER_HOUR (2)
   ) u_dut_small (
      .clock       (clock),
      .reset       (s_reset),
      .reset_count (s_rc),
      .enable      (s_en),
      .fastwatch   (s_fw),
      .one_second  (s_os),
      .one_minute  (s_om),
      .one_hour    (s_oh),
      .sec_count   (s_sec),
      .min_count   (s_min)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_d(input string tag, input int e, input logic os, input logic om,
                          input logic oh, input int sec, input int mn);
      check($sformatf("%s one_second e%0d", tag, e), 32'(d_os), 32'(os));
      check($sformatf("%s one_minute e%0d", tag, e), 32'(d_om), 32'(om));
      check($sformatf("%s one_hour e%0d", tag, e), 32'(d_oh), 32'(oh));
      check($sformatf("%s sec_count e%0d", tag, e), 32'(d_sec), 32'(sec));
      check($sformatf("%s min_count e%0d", tag, e), 32'(d_min), 32'(mn));
   endtask

   task automatic check_s(input string tag, input int e, input logic os, input logic om,
                          input logic oh, input int sec, input int mn);
      check($sformatf("%s one_second e%0d", tag, e), 32'(s_os), 32'(os));
      check($sformatf("%s one_minute e%0d", tag, e), 32'(s_om), 32'(om));
      check($sformatf("%s one_hour e%0d", tag, e), 32'(s_oh), 32'(oh));
      check($sformatf("%s sec_count e%0d", tag, e), 32'(s_sec), 32'(sec));
      check($sformatf("%s min_count e%0d", tag, e), 32'(s_min), 32'(mn));
   endtask

   // Advance one rising edge and settle; inputs set after this apply to the next edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Watchdog: the directed sequence is bounded, this only guards a stuck run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      d_reset = 1'b0; d_rc = 1'b0; d_en = 1'b1; d_fw = 1'b0;
      s_reset = 1'b0; s_rc = 1'b0; s_en = 1'b1; s_fw = 1'b0;

      // ---- Reset state, both instances
      tick();
      tick();
      check_d("reset_def", 0, 1'b0, 1'b0, 1'b0, 0, 0);
      check_s("reset_small", 0, 1'b0, 1'b0, 1'b0, 0, 0);

      // ---- Default: free run through first minute plus one second
      d_reset = 1'b1;
      for (int e = 1; e <= 15616; e++) begin
         tick();
         check_d("run_def", e, (e % 256) == 0, (e % 15360) == 0, 1'b0,
                 (e / 256) % 60, (e / 15360) % 60);
      end

      // ---- Default: pause on edges 100..199 and a one-edge pause after a strobe
      d_reset = 1'b0;
      tick();
      check_d("pause_reset", 0, 1'b0, 1'b0, 1'b0, 0, 0);
      d_reset = 1'b1;
      for (int e = 1; e <= 620; e++) begin
         d_en = !((e >= 100 && e <= 199) || e == 357);
         tick();
         check_d("pause", e, (e == 356) || (e == 613), 1'b0, 1'b0,
                 (e >= 613) ? 2 : ((e >= 356) ? 1 : 0), 0);
      end
      d_en = 1'b1;

      // ---- Default: reset_count on the edge that would be the minute event
      d_reset = 1'b0;
      tick();
      d_reset = 1'b1;
      for (int e = 1; e <= 15359; e++) begin
         tick();
         check_d("pre_rc", e, (e % 256) == 0, 1'b0, 1'b0, (e / 256) % 60, 0);
      end
      d_rc = 1'b1;
      tick();
      check_d("rc_on_se", 15360, 1'b0, 1'b0, 1'b0, 0, 0);
      d_rc = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         check_d("after_rc", k, k == 256, 1'b0, 1'b0, (k == 256) ? 1 : 0, 0);
      end
      d_reset = 1'b0;

      // ---- Small: normal counting, all strobes coincide on edge 24
      s_reset = 1'b1;
      for (int e = 1; e <= 48; e++) begin
         tick();
         check_s("run_small", e, (e % 4) == 0, (e % 12) == 0, (e % 24) == 0,
                 (e / 4) % 3, (e / 12) % 2);
      end

      // ---- Small: fastwatch from reset
      s_reset = 1'b0;
      s_fw    = 1'b1;
      tick();
      check_s("fw_reset", 0, 1'b0, 1'b0, 1'b0, 0, 0);
      s_reset = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         check_s("fw", e, (e % 4) == 0, (e % 4) == 0, (e % 8) == 0, 0, (e / 4) % 2);
      end

      // ---- Small: fastwatch pulse between SEs is ignored; entering drops sec_count
      s_reset = 1'b0;
      s_fw    = 1'b0;
      tick();
      s_reset = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         s_fw = (e == 2) || (e >= 5);
         tick();
         check_s("mode", e, (e % 4) == 0, (e == 8) || (e == 12), e == 12,
                 (e >= 4 && e < 8) ? 1 : 0, (e >= 8 && e < 12) ? 1 : 0);
      end
      s_fw = 1'b0;

      // ---- Small: reset held low three cycles mid-minute
      s_reset = 1'b0;
      tick();
      s_reset = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check_s("pre_mid", e, (e % 4) == 0, 1'b0, 1'b0, e / 4, 0);
      end
      s_reset = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         tick();
         check_s("mid_reset", r, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      s_reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_s("post_mid", k, (k % 4) == 0, 1'b0, 1'b0, k / 4, 0);
      end

      // ---- Small: reset_count clears even while paused
      tick();
      tick();
      check_s("pre_rc_pause", 10, 1'b0, 1'b0, 1'b0, 2, 0);
      s_en = 1'b0;
      s_rc = 1'b1;
      tick();
      check_s("rc_paused", 0, 1'b0, 1'b0, 1'b0, 0, 0);
      s_rc = 1'b0;
      s_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_s("after_rc_small", k, k == 4, 1'b0, 1'b0, (k == 4) ? 1 : 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
